// File: rtl/tff_seq_pkg.sv
// Shared definitions for the T flip-flop count sequencer: state encoding
// and the default bank width.
package tff_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop storage cell: toggles on a rising clock edge when t=1,
// cleared asynchronously by rst.
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  // Toggle storage; rst forces the cell to 0 immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_count_sequencer.sv
// Programmable, pausable up/down counter built from a bank of T flip-flops.
// The sequencer owns the bank: it clears it at the start of every run by
// toggling each set bit, then steps it with carry/borrow toggle patterns
// until the latched terminal value is reached.
module tff_count_sequencer
  import tff_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] limit_r;
  logic             up_r;
  logic             terminal;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] borrow;

  // The run ends when the bank matches the terminal value latched at launch
  assign terminal = (q == limit_r);

  // Storage bank: one T flip-flop per count bit, driven by t_vec
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    t_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t_vec[g]),
      .q   (q[g])
    );
  end

  // Toggle patterns for +1 (bit i flips when all lower bits are 1) and
  // -1 (bit i flips when all lower bits are 0)
  always_comb begin
    carry     = '0;
    borrow    = '0;
    carry[0]  = 1'b1;
    borrow[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i]  = carry[i-1]  &  q[i-1];
      borrow[i] = borrow[i-1] & ~q[i-1];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; terminal beats stop in RUN, stop beats start in PAUSE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        state_next = RUN;
      end
      RUN: begin
        if (terminal) begin
          state_next = IDLE;
        end else if (stop) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_next = IDLE;
        end else if (start) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Toggle vector: clear every set bit in CLEAR, step in RUN, hold elsewhere
  always_comb begin
    t_vec = '0;
    unique case (state)
      CLEAR: begin
        t_vec = q;
      end
      RUN: begin
        if (!terminal && !stop) begin
          t_vec = up_r ? carry : borrow;
        end
      end
      default: begin
        t_vec = '0;
      end
    endcase
  end

  // Run parameters are captured only when a new run is launched from IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      limit_r <= '0;
      up_r    <= 1'b1;
    end else if (state == IDLE && start) begin
      limit_r <= limit;
      up_r    <= up;
    end
  end

  // Registered status: busy follows the next state, done pulses on the
  // edge that leaves RUN at the terminal value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == RUN) && terminal;
    end
  end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed bench for tff_count_sequencer (WIDTH=4) with an arithmetic
// reference model and a per-cycle compare process.
module tb_tff_count_sequencer;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         up;
  logic [W-1:0] limit;
  logic [W-1:0] q;
  logic [W-1:0] t_vec;
  logic         busy;
  logic         done;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  tff_count_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .up    (up),
    .limit (limit),
    .q     (q),
    .t_vec (t_vec),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 clearing, 2 counting, 3 paused; count kept as a number
  int           m_mode;
  logic [W-1:0] m_q;
  logic [W-1:0] m_lim;
  logic         m_up;
  logic         m_done;

  function automatic logic [W-1:0] m_next();
    if (m_mode == 1) return '0;
    if (m_mode == 2 && m_q != m_lim && !stop)
      return m_up ? W'((int'(m_q) + 1) % 16) : W'((int'(m_q) + 15) % 16);
    return m_q;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0;
      m_q    <= '0;
      m_lim  <= '0;
      m_up   <= 1'b1;
      m_done <= 1'b0;
    end else begin
      m_q    <= m_next();
      m_done <= (m_mode == 2) && (m_q == m_lim);
      case (m_mode)
        0: if (start) begin m_mode <= 1; m_lim <= limit; m_up <= up; end
        1: m_mode <= 2;
        2: if (m_q == m_lim) m_mode <= 0; else if (stop) m_mode <= 3;
        3: if (stop) m_mode <= 0; else if (start) m_mode <= 2;
        default: m_mode <= 0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: outputs against the model (toggles = present ^ next count)
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model_q",     32'(q),     32'(m_q));
      check("model_t_vec", 32'(t_vec), 32'(m_q ^ m_next()));
      check("model_busy",  32'(busy),  32'(m_mode != 0));
      check("model_done",  32'(done),  32'(m_done));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic u, input logic [W-1:0] l);
    up    = u;
    limit = l;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Counts edges from the last one taken until done is seen high
  task automatic wait_done(input int exp_lat, input string name, input bit disturb);
    int cnt;
    cnt = 0;
    while (cnt < 40) begin
      cyc();
      cnt++;
      if (done) break;
      if (disturb) begin
        start = cnt[0];
        limit = cnt[W-1:0];
        up    = ~up;
      end
    end
    start = 1'b0;
    check(name, cnt, exp_lat);
  endtask

  task automatic wait_q(input logic [W-1:0] val, input string name);
    int cnt;
    cnt = 0;
    while (q != val && cnt < 40) begin
      cyc();
      cnt++;
    end
    check(name, 32'(q == val), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    up    = 1'b1;
    limit = '0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    check("reset_q",     32'(q),     32'd0);
    check("reset_busy",  32'(busy),  32'd0);
    check("reset_done",  32'(done),  32'd0);
    check("reset_t_vec", 32'(t_vec), 32'd0);

    // Up to 9, then up to 5 starting from q=9 (clear toggles 1001)
    launch(1'b1, 4'd9);
    check("up9_busy", 32'(busy), 32'd1);
    wait_done(11, "up9_latency", 1'b0);
    check("up9_q", 32'(q), 32'd9);
    cyc();
    check("up9_hold_q", 32'(q), 32'd9);
    check("up9_done_once", 32'(done), 32'd0);
    launch(1'b1, 4'd5);
    check("clear_t_vec", 32'(t_vec), 32'b1001);
    wait_done(7, "up5_latency", 1'b0);
    check("up5_q", 32'(q), 32'd5);

    // Down to 12 through the wrap 0 -> 15
    launch(1'b0, 4'd12);
    wait_done(6, "down12_latency", 1'b0);
    check("down12_q", 32'(q), 32'd12);

    // Pause at 3 for four cycles, then resume to 10 without clearing
    launch(1'b1, 4'd10);
    wait_q(4'd3, "reach_3");
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("pause_q", 32'(q), 32'd3);
      check("pause_t_vec", 32'(t_vec), 32'd0);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(8, "resume_latency", 1'b0);
    check("resume_q", 32'(q), 32'd10);

    // Abort from PAUSE with start and stop together
    launch(1'b1, 4'd10);
    wait_q(4'd2, "reach_2");
    stop = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_q", 32'(q), 32'd2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("abort_no_done", 32'(done), 32'd0);
    end

    // limit=0 in both directions
    launch(1'b1, 4'd0);
    wait_done(2, "zero_up_latency", 1'b0);
    check("zero_up_q", 32'(q), 32'd0);
    launch(1'b0, 4'd0);
    wait_done(2, "zero_down_latency", 1'b0);
    check("zero_down_q", 32'(q), 32'd0);

    // Inputs wiggling mid-run are ignored; full-scale up does not wrap
    launch(1'b1, 4'd8);
    wait_done(10, "disturb_latency", 1'b1);
    check("disturb_q", 32'(q), 32'd8);
    launch(1'b1, 4'd15);
    wait_done(17, "full_latency", 1'b0);
    check("full_q", 32'(q), 32'd15);
    cyc();
    check("full_no_wrap", 32'(q), 32'd15);

    // Asynchronous reset in the middle of a run at q=6
    launch(1'b1, 4'd10);
    wait_q(4'd6, "reach_6");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_q",    32'(q),    32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_q", 32'(q), 32'd0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tff_count_sequencer.md
Name: tff_count_sequencer

Overview:
Controller that sequences a bank of WIDTH T flip-flops as a programmable, pausable up/down counter.
- Drives each cell's toggle input every cycle.
- Clears the bank before each run.
- Stops at a latched terminal value and reports completion.
- Sits between a control master issuing start/stop and the T flip-flop storage bank, which it owns.

Parameters:
WIDTH, 4, number of T flip-flop cells and width of count and limit.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  launch a new run from IDLE or resume from PAUSE; level sampled each edge
stop  input  1  pause in RUN; abort in PAUSE
up  input  1  direction, 1=up, 0=down; sampled only when a new run is launched
limit  input  WIDTH  terminal count; sampled only when a new run is launched
q  output  WIDTH  T flip-flop bank state (current count)
t_vec  output  WIDTH  toggle enables applied to the bank this cycle (combinational from state, q, up_r)
busy  output  1  1 whenever state != IDLE
done  output  1  single-cycle pulse on normal termination

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, q=0, limit_r=0, up_r=1, done=0, busy=0, t_vec=0. Reset mid-run takes effect immediately, with no done pulse.
- Bank update: q[i] toggles at the edge when t_vec[i]=1. No load path exists; q changes only through toggles.

FSM states: IDLE, CLEAR, RUN, PAUSE.
- IDLE:
  - t_vec=0; q holds its last value.
  - start=1 latches limit_r<=limit and up_r<=up, then goes to CLEAR.
  - stop is ignored.
- CLEAR (exactly 1 cycle):
  - t_vec=q, so every set bit toggles and q=0 at the next edge.
  - Next state is RUN. start and stop are ignored.
- RUN, when q==limit_r (terminal):
  - t_vec=0.
  - Next state is IDLE, done=1 for that one cycle, and q holds at limit_r.
  - Terminal takes priority over stop.
- RUN, otherwise:
  - stop=1: t_vec=0, next state is PAUSE.
  - Else, up_r=1: t_vec[0]=1 and t_vec[i]=&q[i-1:0], i.e. +1 mod 2^WIDTH.
  - Else, up_r=0: t_vec[0]=1 and t_vec[i]=&(~q[i-1:0]), i.e. -1 mod 2^WIDTH.
  - start is ignored.
- PAUSE:
  - t_vec=0; q holds.
  - stop=1 aborts to IDLE with no done; stop wins over a simultaneous start.
  - Else start=1 resumes to RUN with no clear; limit_r and up_r are unchanged.
- Registered outputs: done and busy are registered. busy rises the edge after start is accepted and falls on the same edge as done rises.
- Latency, measured from the edge that samples start in IDLE:
  - Up: done is high in cycle limit+2.
  - Down: done is high in cycle ((2^WIDTH - limit) mod 2^WIDTH)+2.
  - limit=0: done is high in cycle 2 with q=0, in either direction.
- Wrap-around: down counting from 0 wraps to 2^WIDTH-1. Up counting with limit=2^WIDTH-1 ends at all-ones without wrapping.
- Changes to limit or up during a run have no effect.

Decomposition:
- Package tff_seq_pkg:
  - state encoding: IDLE=2'd0, CLEAR=2'd1, RUN=2'd2, PAUSE=2'd3;
  - default WIDTH constant.
- Sub-module t_ff_cell:
  - a single T flip-flop with ports clk, rst (async active-high, clears to 0), t, q;
  - instantiated WIDTH times with a generate loop.
- Toggle-vector logic and the FSM stay in tff_count_sequencer.

Test Plan:
1. Reset: assert rst asynchronously mid-RUN with q=6 -> q=0, busy=0, done=0 before the next clk edge; after release the block is in IDLE.
2. Up, WIDTH=4, limit=9, start from q=0 -> busy=1; q steps 0..9; done pulses for exactly 1 cycle, 11 cycles after start; q holds 9. Then limit=5, up -> CLEAR cycle shows t_vec=4'b1001 and q becomes 0; q steps 0..5; done 7 cycles after start.
3. Down, limit=12 -> q sequence 0,15,14,13,12; done 6 cycles after start; q holds 12.
4. Pause/resume, up, limit=10: stop when q=3 -> q holds 3 and t_vec=0 for 4 cycles; start -> q continues 4..10 with no clear; done once.
5. Abort and corner cases:
   - stop in PAUSE with start=1 the same cycle -> IDLE, busy=0, no done, q held.
   - limit=0 -> done in cycle 2 with q=0.
6. Ignored inputs:
   - start pulses during RUN, and limit/up changes mid-run -> no effect.
   - up, limit=15 -> ends at q=15, done at cycle 17, no wrap to 0.
